// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and slice-width helper for adder_pipe
package adder_pkg;
    localparam logic ADD_OP = 1'b0;
    localparam logic SUB_OP = 1'b1;

    // Slice width; 0 flags a width that does not split evenly so the top can refuse to elaborate
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0 && width % stages == 0) ? width / stages : 0;
    endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: CHUNK-bit registered adder slice with carry out and signed-overflow term
module adder_slice
    import adder_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             cin,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    logic [CHUNK:0] full;
    logic           msb_cin;

    // Slice sum; the carry into the MSB is recovered from the MSB sum bit
    always_comb begin
        full    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];
    end

    // Slice register; clr is only driven on the output slice
    always_ff @(posedge clk) begin
        if (clr) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (en) begin
            sum  <= full[CHUNK-1:0];
            cout <= full[CHUNK];
            ovf  <= full[CHUNK] ^ msb_cin;
        end
    end
endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: WIDTH-bit add/subtract with the carry chain split over STAGES registered slices
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH:0]   c_o,
    output logic             ovf_o
);
    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (CHUNK == 0) begin : g_bad_split
        $fatal(1, "adder_pipe: WIDTH must be a positive multiple of STAGES");
    end

    logic              advance;
    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  b_in;
    logic [WIDTH-1:0]  res;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic              sub_q [STAGES];
    logic [CHUNK-1:0]  s_sum [STAGES];
    logic              s_cout [STAGES];
    logic              s_ovf [STAGES];

    // Stall control, subtract as a + ~b + 1, and output assembly from the last stage
    always_comb begin
        advance = rst || !valid_o || ready_i;
        b_in    = (sub_i == SUB_OP) ? ~b_i : b_i;
        res     = r_q[STAGES-1];
        res[(STAGES-1)*CHUNK +: CHUNK] = s_sum[STAGES-1];
    end

    assign ready_o = advance;
    assign valid_o = v[STAGES-1];
    assign c_o     = {sub_q[STAGES-1] ^ s_cout[STAGES-1], res};
    assign ovf_o   = s_ovf[STAGES-1];

    // Per-stage valid bits; a bubble enters whenever valid_i is low on an advancing edge
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else if (advance) begin
            for (int k = STAGES - 1; k > 0; k--) v[k] <= v[k-1];
            v[0] <= valid_i;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] pa, pb, pr;
        logic             ps, pc;
        if (k == 0) begin : g_head
            assign pa = a_i;
            assign pb = b_in;
            assign ps = sub_i;
            assign pc = sub_i;
            assign pr = '0;
        end else begin : g_body
            assign pa = a_q[k-1];
            assign pb = b_q[k-1];
            assign ps = sub_q[k-1];
            assign pc = s_cout[k-1];
            // Deskew: results of earlier slices plus the chunk the previous slice just produced
            always_comb begin
                pr = r_q[k-1];
                pr[(k-1)*CHUNK +: CHUNK] = s_sum[k-1];
            end
        end

        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .clk  (clk),
            .clr  (rst && k == STAGES - 1),
            .en   (advance),
            .cin  (pc),
            .a    (pa[k*CHUNK +: CHUNK]),
            .b    (pb[k*CHUNK +: CHUNK]),
            .sum  (s_sum[k]),
            .cout (s_cout[k]),
            .ovf  (s_ovf[k])
        );

        // Skew/deskew registers; the last stage is the output register and alone takes reset
        always_ff @(posedge clk) begin
            if (rst && k == STAGES - 1) begin
                r_q[k]   <= '0;
                sub_q[k] <= 1'b0;
            end else if (advance) begin
                a_q[k]   <= pa;
                b_q[k]   <= pb;
                sub_q[k] <= ps;
                r_q[k]   <= pr;
            end
        end
    end
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: randomized and directed checks of adder_pipe against a behavioural model
module tb_adder_pipe;
    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_i = 1'b0, sub_i = 1'b0, ready_i = 1'b1;
    logic [W-1:0] a_i = '0, b_i = '0;
    logic         ready_o, valid_o, ovf_o;
    logic [W:0]   c_o;
    logic [7:0]   a8 = '0, b8 = '0;
    logic         sub8 = 1'b0;
    logic         r8, v8, ovf8;
    logic [8:0]   c8;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .sub_i(sub_i),
        .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i), .c_o(c_o), .ovf_o(ovf_o)
    );

    adder_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .valid_i(1'b1), .ready_o(r8), .sub_i(sub8),
        .a_i(a8), .b_i(b8), .valid_o(v8), .ready_i(1'b1), .c_o(c8), .ovf_o(ovf8)
    );

    int checks = 0, failures = 0;
    int sent = 0, got = 0;
    bit chk_en = 1'b0;
    bit done = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic longint sext(input longint x, input int w);
        return x[w-1] ? x - (longint'(1) << w) : x;
    endfunction

    function automatic longint gold_c(input longint a, input longint b, input bit sub, input int w);
        longint m;
        m = (longint'(1) << (w + 1)) - 1;
        return sub ? ((a - b) & m) : ((a + b) & m);
    endfunction

    function automatic bit gold_ovf(input longint a, input longint b, input bit sub, input int w);
        longint t, r;
        t = sub ? sext(a, w) - sext(b, w) : sext(a, w) + sext(b, w);
        r = sext(gold_c(a, b, sub, w) & ((longint'(1) << w) - 1), w);
        return t != r;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    bit         mv [S];
    logic [W:0] mc [S];
    bit         mo [S];
    bit         after_rst = 1'b0;
    bit         e8v = 1'b0;
    logic [8:0] e8c;
    bit         e8o;

    always @(posedge clk) begin
        after_rst = rst;
        if (rst) begin
            foreach (mv[k]) mv[k] = 1'b0;
            e8v = 1'b0;
        end else begin
            if (!mv[S-1] || ready_i) begin
                for (int k = S - 1; k > 0; k--) begin
                    mv[k] = mv[k-1];
                    mc[k] = mc[k-1];
                    mo[k] = mo[k-1];
                end
                mv[0] = valid_i;
                mc[0] = (W+1)'(gold_c(a_i, b_i, sub_i, W));
                mo[0] = gold_ovf(a_i, b_i, sub_i, W);
            end
            e8v = 1'b1;
            e8c = 9'(gold_c(a8, b8, sub8, 8));
            e8o = gold_ovf(a8, b8, sub8, 8);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_o", valid_o, mv[S-1]);
            check("ready_o", ready_o, rst || !mv[S-1] || ready_i);
            if (mv[S-1]) begin
                check("c_o", c_o, mc[S-1]);
                check("ovf_o", ovf_o, mo[S-1]);
            end
            if (after_rst) begin
                check("c_o_after_rst", c_o, 0);
                check("ovf_o_after_rst", ovf_o, 0);
                check("c8_after_rst", c8, 0);
            end
            check("valid8", v8, e8v);
            check("ready8", r8, 1);
            if (e8v) begin
                check("c8", c8, e8c);
                check("ovf8", ovf8, e8o);
            end
            if (valid_o && ready_i && !rst) got++;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bit acc;
        int g;
        g = 0;
        valid_i = 1'b1;
        a_i = a;
        b_i = b;
        sub_i = s;
        do begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 200);
        check("send_accept", 64'(acc), 1);
        if (acc) sent++;
        valid_i = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic [W:0] ec, input logic eo);
        int n;
        ready_i = 1'b1;
        send(a, b, s);
        n = 1;
        while (!valid_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, "_latency"}, n, S);
        check({nm, "_c"}, c_o, ec);
        check({nm, "_ovf"}, ovf_o, eo);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int gb, n;
        logic [W:0] held;
        void'($urandom(1234));
        valid_i = 1'b1;
        a_i = 32'hDEAD_BEEF;
        b_i = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        valid_i = 1'b0;
        chk_en = 1'b1;
        check("rst_valid_o", valid_o, 0);
        check("rst_ready_o", ready_o, 1);
        check("rst_c_o", c_o, 0);

        a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0;
        @(posedge clk);
        #1;
        check("legacy_ff_valid", v8, 1);
        check("legacy_ff_c", c8, 9'h100);
        check("legacy_ff_ovf", ovf8, 0);
        a8 = 8'h7F; b8 = 8'h01;
        @(posedge clk);
        #1;
        check("legacy_7f_c", c8, 9'h080);
        check("legacy_7f_ovf", ovf8, 1);

        directed("carry_chain", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 33'h0_0100_0000, 1'b0);
        directed("borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 33'h1_FFFF_FFFE, 1'b0);
        directed("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 33'h0_7FFF_FFFF, 1'b1);
        directed("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE, 1'b0);
        directed("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000, 1'b1);

        gb = got;
        fork
            begin
                for (int i = 0; i < 8; i++) send(32'h0100_0000 * i + 32'h00FF_FFF0 + i, 32'h0000_0011 * i, i[0]);
            end
            begin
                n = 0;
                while (!valid_o && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("bp_valid_seen", valid_o, 1);
                held = c_o;
                ready_i = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    check("bp_ready_low", ready_o, 0);
                    check("bp_c_held", c_o, held);
                end
                ready_i = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("bp_count", got - gb, 8);

        gb = got;
        ready_i = 1'b1;
        send(32'h1111_1111, 32'h2222_2222, 1'b0);
        send(32'h3333_3333, 32'h4444_4444, 1'b1);
        send(32'h5555_5555, 32'h6666_6666, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_flush", got - gb, 0);
        directed("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789, 1'b0);

        sent = 0;
        got = 0;
        fork
            begin
                repeat (10000) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ready_i = $urandom_range(0, 3) != 0;
                    a8 = 8'($urandom());
                    b8 = 8'($urandom());
                    sub8 = 1'($urandom_range(0, 1));
                end
            end
        join
        ready_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("random_count", got, sent);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised successor to the 8-bit registered adder: WIDTH-bit add/subtract with a carry chain split across STAGES register stages.
- Valid/ready handshake with backpressure; one operation accepted per cycle when not stalled.
- Used wherever wide sums must close timing at 50 MHz and beyond.
- Drop-in for the legacy block when WIDTH=8, STAGES=1, valid tied high, ready tied high.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of carry-chain slices; CHUNK = WIDTH/STAGES; range 1..WIDTH.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  input operands valid.
- ready_o  out  1  block can accept an operation this cycle.
- sub_i  in  1  0 = add, 1 = subtract (a - b); qualified by valid_i.
- a_i  in  WIDTH  operand A, unsigned or two's complement.
- b_i  in  WIDTH  operand B.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- c_o  out  WIDTH+1  result.
- ovf_o  out  1  signed overflow of the WIDTH-bit result.

Behaviour:
- Arithmetic: c_o = ({1'b0,a} + {1'b0,b}) mod 2^(WIDTH+1) for add, and ({1'b0,a} - {1'b0,b}) mod 2^(WIDTH+1) for subtract.
  - For add, c_o[WIDTH] is the carry out.
  - For subtract, c_o[WIDTH] is the borrow: 1 iff a < b, unsigned.
- Subtract is implemented as a + ~b with carry-in 1. The top bit is derived so that it matches the formula above.
- ovf_o = 1 iff the signed WIDTH-bit result c_o[WIDTH-1:0] differs from the true signed result.
- Slicing: stage k (0..STAGES-1) adds chunk k of both operands plus the registered carry from stage k-1. Stage 0 takes carry-in = sub_i.
  - Operand chunks above k travel through skew registers.
  - Result chunks below k travel through de-skew registers, so all chunks of one operation emerge together.
- Latency: exactly STAGES cycles from the accepting edge (valid_i && ready_o) to valid_o, given no stall. Throughput is 1 operation per cycle.
- Stall: advance = !valid_o || ready_i. ready_o = advance (combinational).
  - When advance = 0, every pipeline register holds, including the valid bits, c_o and ovf_o.
  - When advance = 1, every stage shifts by one; a bubble enters when valid_i = 0.
- Output stability: while valid_o && !ready_i, c_o and ovf_o are held bit-stable.
- Data outputs are undefined-but-deterministic when valid_o = 0. Data registers carry no reset; only valid bits are reset.
- Reset: while rst = 1, all stage valid bits clear and ready_o = 1. The cycle after rst deasserts: valid_o = 0, c_o = 0, ovf_o = 0; for c_o and ovf_o this is forced by an output reset.
- Reset mid-operation: in-flight operations are discarded and no valid_o pulse appears for them. Inputs presented with valid_i in the reset cycle are dropped.
- Simultaneous accept and emit: when the pipeline is full and ready_i = 1 with valid_i = 1, both transfers occur in the same cycle with no bubble.
- Wrap-around: all-ones + all-ones gives c_o = {1, all-ones except LSB 0}, with no saturation.
- STAGES=1: there are no skew registers; behaviour is the legacy single registered adder plus handshake.

Decomposition:
- Package adder_pkg:
  - mode constants ADD_OP = 1'b0, SUB_OP = 1'b1.
  - function to compute CHUNK with an elaboration-time check that WIDTH % STAGES == 0 (fatal otherwise).
- Sub-module adder_slice:
  - CHUNK-bit registered slice: inputs a, b, cin, en; outputs sum[CHUNK-1:0] and cout.
  - Instantiated STAGES times in a generate loop.
  - The top slice also produces the signed-overflow term from its MSB carry-in and carry-out.

Test Plan:
- WIDTH=8, STAGES=1, ready_i=1: accept 0xFF+0x01 -> valid_o next cycle with c_o=0x100, ovf_o=0. Then 0x7F+0x01 -> c_o=0x080, ovf_o=1.
- WIDTH=32, STAGES=4: 0x00FFFFFF+0x00000001 (carry across all chunk boundaries) -> c_o=0x001000000 exactly 4 cycles after accept.
- Subtract, WIDTH=32: 0x00000005-0x00000007 -> c_o=0x1FFFFFFFE (borrow=1), ovf_o=0. Then 0x80000000-0x00000001 -> c_o=0x07FFFFFFF, ovf_o=1.
- Backpressure: stream 8 back-to-back operations, drop ready_i for 3 cycles once valid_o rises.
  - ready_o=0 during the stall; c_o held stable.
  - All 8 results arrive in order, none lost or duplicated.
- Reset mid-flight: assert rst for 1 cycle with 3 operations in the pipe -> no valid_o for them. A new operation accepted after reset emerges after STAGES cycles.
- Random regression (seeded, 10k operations, random valid_i, ready_i, sub_i) checked against the golden formula and a queue-based scoreboard -> zero mismatches.
